bimodal_counter_table: RTL and testbench

//  Parametrised bimodal direction-prediction table: 2^IDX_BITS saturating counters of CTR_BITS.

---
 rtl/bimodal_counter_table.sv | 118 +++++++++++
 tb/tb_bimodal_counter_table.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_counter_table.sv
// Bimodal direction-prediction table: 2^IDX_BITS saturating counters, one fetch read and one
// execute write-back per cycle, self-initialised by a sweep after reset or soft clear.
module bimodal_counter_table #(
    parameter int unsigned IDX_BITS   = 12,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned INIT_VALUE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_clear,
    input  logic [31:0]         fetch_pc,
    input  logic                fetch_stall,
    output logic                pred_valid,
    output logic                pred_dir,
    output logic [CTR_BITS-1:0] pred_ctr,
    output logic [IDX_BITS-1:0] pred_index,
    output logic                init_busy,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_index,
    input  logic [CTR_BITS-1:0] upd_ctr,
    input  logic                upd_dir
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_VALUE);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] sweep_ptr;
    logic [CTR_BITS-1:0] ctr_mem [ENTRIES];

    logic                run_active;
    logic [CTR_BITS-1:0] upd_next;
    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [CTR_BITS-1:0] wr_data;
    logic [IDX_BITS-1:0] rd_idx;
    logic [CTR_BITS-1:0] rd_data;
    logic                unused_pc_bits;

    assign run_active     = (state == ST_RUN) && !soft_clear;
    assign rd_idx         = fetch_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

    // Saturating step of the counter value carried down the pipe (no read-modify-write)
    always_comb begin
        upd_next = upd_ctr;
        if (upd_dir) begin
            if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_BITS'(1);
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - CTR_BITS'(1);
        end
    end

    // Single write port shared by the init sweep and execute write-back
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_index;
        wr_data = upd_next;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_ptr;
            wr_data = CTR_INIT;
        end else if (run_active && upd_en) begin
            wr_en = 1'b1;
        end
    end

    // Write-first bypass so a same-cycle update is visible to the fetch read
    assign rd_data = (wr_en && (wr_idx == rd_idx)) ? wr_data : ctr_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) ctr_mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            sweep_ptr  <= '0;
            init_busy  <= 1'b1;
            pred_valid <= 1'b0;
            pred_dir   <= 1'b0;
            pred_ctr   <= '0;
            pred_index <= '0;
        end else if (soft_clear) begin
            state      <= ST_INIT;
            sweep_ptr  <= '0;
            init_busy  <= 1'b1;
            pred_valid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    pred_valid <= 1'b0;
                    sweep_ptr  <= sweep_ptr + IDX_BITS'(1);
                    if (&sweep_ptr) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!fetch_stall) begin
                        pred_valid <= 1'b1;
                        pred_ctr   <= rd_data;
                        pred_dir   <= rd_data[CTR_BITS-1];
                        pred_index <= rd_idx;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bimodal_counter_table.sv
// Self-checking bench for bimodal_counter_table (16 entries x 2-bit counters, init value 1)
// using an array-of-integers reference model and directed plus random stimulus.
module tb_bimodal_counter_table;

    logic        clk;
    logic        reset;
    logic        soft_clear;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        pred_valid;
    logic        pred_dir;
    logic [1:0]  pred_ctr;
    logic [3:0]  pred_index;
    logic        init_busy;
    logic        upd_en;
    logic [3:0]  upd_index;
    logic [1:0]  upd_ctr;
    logic        upd_dir;

    int total = 0;
    int bad   = 0;

    int model [16];
    int exp_valid;
    int exp_ctr;
    int exp_idx;

    bimodal_counter_table #(
        .IDX_BITS  (4),
        .CTR_BITS  (2),
        .INIT_VALUE(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_clear (soft_clear),
        .fetch_pc   (fetch_pc),
        .fetch_stall(fetch_stall),
        .pred_valid (pred_valid),
        .pred_dir   (pred_dir),
        .pred_ctr   (pred_ctr),
        .pred_index (pred_index),
        .init_busy  (init_busy),
        .upd_en     (upd_en),
        .upd_index  (upd_index),
        .upd_ctr    (upd_ctr),
        .upd_dir    (upd_dir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int nxt(input int c, input bit d);
        if (d) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic check_pred(input string tag);
        chk({tag, "_valid"}, 32'(pred_valid), 32'(exp_valid));
        chk({tag, "_index"}, 32'(pred_index), 32'(exp_idx));
        chk({tag, "_ctr"},   32'(pred_ctr),   32'(exp_ctr));
        chk({tag, "_dir"},   32'(pred_dir),   32'(exp_ctr / 2));
    endtask

    // One RUN-state cycle: drive, clock, advance the model, compare
    task automatic run_cycle(input string tag, input logic [31:0] pc, input bit stall,
                             input bit ue, input int ui, input int uc, input bit ud);
        int idx;
        fetch_pc    = pc;
        fetch_stall = stall;
        upd_en      = ue;
        upd_index   = 4'(ui);
        upd_ctr     = 2'(uc);
        upd_dir     = ud;
        @(posedge clk);
        #1;
        idx = int'((pc >> 2) & 32'hF);
        if (!stall) begin
            exp_valid = 1;
            exp_idx   = idx;
            exp_ctr   = (ue && ui == idx) ? nxt(uc, ud) : model[idx];
        end
        if (ue) model[ui] = nxt(uc, ud);
        upd_en = 1'b0;
        check_pred(tag);
    endtask

    task automatic count_sweep(input string tag);
        int n;
        n = 0;
        while (init_busy && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_sweep_len"}, 32'(n), 32'd16);
        chk({tag, "_valid_at_run"}, 32'(pred_valid), 32'd0);
        for (int i = 0; i < 16; i++) model[i] = 1;
        exp_valid = 0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++)
            run_cycle(tag, ($urandom & 32'hFFFF_FFC0) | 32'(i << 2) | 32'($urandom_range(0, 3)),
                      0, 0, 0, 0, 0);
    endtask

    initial begin
        reset       = 1'b0;
        soft_clear  = 1'b0;
        fetch_pc    = '0;
        fetch_stall = 1'b0;
        upd_en      = 1'b0;
        upd_index   = '0;
        upd_ctr     = '0;
        upd_dir     = 1'b0;
        exp_valid   = 0;
        exp_ctr     = 0;
        exp_idx     = 0;
        for (int i = 0; i < 16; i++) model[i] = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(init_busy), 32'd1);
        check_pred("rst");

        // Sweep after reset release; stray updates and stalls must be ignored
        reset       = 1'b1;
        upd_en      = 1'b1;
        upd_index   = 4'd0;
        upd_ctr     = 2'd3;
        upd_dir     = 1'b1;
        fetch_stall = 1'b1;
        count_sweep("boot");
        read_all("boot_read");

        // Directed updates and saturation
        run_cycle("u3a", 32'h40, 0, 1, 3, 1, 1);
        run_cycle("r3a", 32'h0C, 0, 0, 0, 0, 0);
        chk("idx3_inc", 32'(pred_ctr), 32'd2);
        chk("idx3_dir", 32'(pred_dir), 32'd1);
        run_cycle("u3b", 32'h40, 0, 1, 3, 3, 1);
        run_cycle("r3b", 32'h0C, 0, 0, 0, 0, 0);
        chk("idx3_sat_hi", 32'(pred_ctr), 32'd3);
        run_cycle("u5a", 32'h40, 0, 1, 5, 0, 0);
        run_cycle("r5a", 32'h14, 0, 0, 0, 0, 0);
        chk("idx5_sat_lo", 32'(pred_ctr), 32'd0);
        run_cycle("u5b", 32'h40, 0, 1, 5, 3, 0);
        run_cycle("r5b", 32'h14, 0, 0, 0, 0, 0);
        chk("idx5_dec", 32'(pred_ctr), 32'd2);
        run_cycle("byp7", 32'h1C, 0, 1, 7, 1, 1);
        chk("idx7_bypass", 32'(pred_ctr), 32'd2);
        run_cycle("u9a", 32'h00, 0, 1, 9, 0, 1);
        run_cycle("u9b", 32'h00, 0, 1, 9, 3, 0);
        run_cycle("r9", 32'h24, 0, 0, 0, 0, 0);
        chk("idx9_last_wins", 32'(pred_ctr), 32'd2);

        // Stall holds outputs while PC moves
        run_cycle("stall_base", 32'h14, 0, 0, 0, 0, 0);
        run_cycle("stall1", 32'h20, 1, 0, 0, 0, 0);
        run_cycle("stall2", 32'h24, 1, 1, 5, 0, 1);
        run_cycle("stall3", 32'h28, 1, 0, 0, 0, 0);
        chk("stall_hold_idx", 32'(pred_index), 32'd5);
        run_cycle("stall_rel", 32'h2C, 0, 0, 0, 0, 0);
        chk("stall_rel_idx", 32'(pred_index), 32'd11);

        // Random traffic
        for (int k = 0; k < 300; k++)
            run_cycle("rand", $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                      $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));

        // Soft clear, then again mid-sweep at pointer 9
        soft_clear = 1'b1;
        @(posedge clk);
        #1;
        soft_clear = 1'b0;
        exp_valid  = 0;
        chk("sc_busy", 32'(init_busy), 32'd1);
        chk("sc_valid", 32'(pred_valid), 32'd0);
        upd_en    = 1'b1;
        upd_index = 4'd0;
        upd_ctr   = 2'd3;
        upd_dir   = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("sc_mid_busy", 32'(init_busy), 32'd1);
        soft_clear = 1'b1;
        @(posedge clk);
        #1;
        soft_clear = 1'b0;
        count_sweep("sc");
        read_all("sc_read");

        // Async reset mid-sweep
        for (int k = 0; k < 20; k++)
            run_cycle("pre_rst", $urandom, 0, 1, $urandom_range(0, 15), $urandom_range(0, 3),
                      $urandom_range(0, 1));
        soft_clear = 1'b1;
        @(posedge clk);
        #1;
        soft_clear = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_valid = 0;
        exp_ctr   = 0;
        exp_idx   = 0;
        chk("arst_busy", 32'(init_busy), 32'd1);
        check_pred("arst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        count_sweep("arst");
        read_all("arst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
